// File: rtl/counter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : counter_pkg
// Purpose  : Shared mode constants, one-shot FSM state encoding and helpers
//            for the programmable modulus counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } os_state_t;

  // The reserved mode behaves exactly like wrap mode.
  function automatic logic is_wrap_mode(input logic [1:0] m);
    return (m == MODE_WRAP) || (m == MODE_RSVD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_mod_counter_oneshot_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : oneshot_ctrl
// Purpose  : IDLE/RUN/DONE controller for one-shot mode. Decides when the
//            datapath may step and when a start reloads the count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module oneshot_ctrl
  import counter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic start,
  input  logic oneshot_mode,
  input  logic enable,
  input  logic start_terminal,  // load_value already terminal for direction
  input  logic step_terminal,   // result of the pending step is terminal
  output logic step_allow,
  output logic running,
  output logic done,
  output logic load_start
);

  os_state_t r_state;
  os_state_t w_state_nxt;

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and start strobe, following clear > load > start > step.
  always_comb begin
    w_state_nxt = r_state;
    load_start  = 1'b0;
    if (clear || !oneshot_mode) begin
      w_state_nxt = ST_IDLE;
    end else if (load) begin
      w_state_nxt = r_state;
    end else if (start) begin
      load_start  = 1'b1;
      w_state_nxt = start_terminal ? ST_DONE : ST_RUN;
    end else if ((r_state == ST_RUN) && enable && step_terminal) begin
      w_state_nxt = ST_DONE;
    end
  end

  assign step_allow = (r_state == ST_RUN);
  assign running    = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/prog_mod_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : prog_mod_counter
// Purpose  : Programmable-modulus up/down counter with wrap, saturate and
//            one-shot modes, terminal pulse, cascade carry and wrap counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module prog_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [WIDTH-1:0]  max_value,
  input  logic              up_down,
  input  logic [1:0]        mode,
  input  logic              start,
  output logic [WIDTH-1:0]  count,
  output logic              terminal_count,
  output logic              carry_out,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              running,
  output logic              done
);

  logic [WIDTH-1:0]  r_count;
  logic              r_tc_pulse;
  logic [WRAP_W-1:0] r_wrap_count;

  logic              w_wrap_mode;
  logic              w_sat_mode;
  logic              w_os_mode;
  logic              w_terminal;
  logic [WIDTH-1:0]  w_step_val;
  logic              w_step_term;
  logic              w_start_term;
  logic              w_step_allow;
  logic              w_load_start;
  logic              w_step_take;

  assign w_wrap_mode = is_wrap_mode(mode);
  assign w_sat_mode  = (mode == MODE_SAT);
  assign w_os_mode   = (mode == MODE_ONESHOT);

  // Terminal state: at/above the modulus going up, at zero going down.
  assign w_terminal = up_down ? (r_count >= max_value) : (r_count == '0);

  // A step from the terminal state wraps to the opposite end.
  assign w_step_val = w_terminal ? (up_down ? '0 : max_value)
                                 : (up_down ? r_count + 1'b1 : r_count - 1'b1);

  assign w_step_term  = up_down ? (w_step_val >= max_value) : (w_step_val == '0);
  assign w_start_term = up_down ? (load_value >= max_value) : (load_value == '0);

  // Saturate mode refuses to step out of the terminal state.
  assign w_step_take = enable && (w_wrap_mode
                                  || (w_sat_mode && !w_terminal)
                                  || (w_os_mode && w_step_allow));

  oneshot_ctrl u_oneshot_ctrl (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .load           (load),
    .start          (start),
    .oneshot_mode   (w_os_mode),
    .enable         (enable),
    .start_terminal (w_start_term),
    .step_terminal  (w_step_term),
    .step_allow     (w_step_allow),
    .running        (running),
    .done           (done),
    .load_start     (w_load_start)
  );

  // Count, terminal pulse and wrap counter, priority reset > clear > load > start > step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_tc_pulse   <= 1'b0;
      r_wrap_count <= '0;
    end else if (clear) begin
      r_count      <= '0;
      r_tc_pulse   <= 1'b0;
      r_wrap_count <= '0;
    end else if (load || w_load_start) begin
      r_count      <= load_value;
      r_tc_pulse   <= 1'b0;
    end else if (w_step_take) begin
      r_count      <= w_step_val;
      r_tc_pulse   <= w_step_term;
      if (w_terminal && !(&r_wrap_count))
        r_wrap_count <= r_wrap_count + 1'b1;
    end else begin
      r_tc_pulse   <= 1'b0;
    end
  end

  assign count          = r_count;
  assign tc_pulse       = r_tc_pulse;
  assign wrap_count     = r_wrap_count;
  assign terminal_count = w_terminal;
  assign carry_out      = enable && w_terminal && w_wrap_mode;

endmodule
`default_nettype wire

// File: tb/tb_prog_mod_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_prog_mod_counter
// Purpose  : Self-checking bench for prog_mod_counter (WIDTH=8, WRAP_W=4)
//            with a reference model feeding an expectation queue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n, enable, clear, load, up_down, start;
  logic [7:0] load_value, max_value;
  logic [1:0] mode;
  wire  [7:0] count;
  wire        terminal_count, carry_out, tc_pulse, running, done;
  wire  [3:0] wrap_count;

  wire  [14:0] obs = {count, tc_pulse, wrap_count, running, done};

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state (0 idle, 1 run, 2 done)
  logic [7:0] m_count = '0;
  logic       m_pulse = 1'b0;
  logic [3:0] m_wrap  = '0;
  int         m_st    = 0;

  logic [14:0] sb[$];
  logic [14:0] e;

  prog_mod_counter #(.WIDTH(8), .WRAP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .max_value(max_value), .up_down(up_down),
    .mode(mode), .start(start), .count(count), .terminal_count(terminal_count),
    .carry_out(carry_out), .tc_pulse(tc_pulse), .wrap_count(wrap_count),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic       tc, os, take, rterm;
    logic [7:0] nv;
    if (!reset_n) begin
      m_count = 0; m_pulse = 0; m_wrap = 0; m_st = 0;
      return;
    end
    os = (mode == 2'b10);
    tc = up_down ? (m_count >= max_value) : (m_count == 0);
    if (clear) begin
      m_count = 0; m_pulse = 0; m_wrap = 0; m_st = 0;
    end else if (load) begin
      m_count = load_value; m_pulse = 0;
    end else if (os && start) begin
      m_count = load_value; m_pulse = 0;
      m_st = (up_down ? (load_value >= max_value) : (load_value == 0)) ? 2 : 1;
    end else begin
      take = enable && (mode == 2'b00 || mode == 2'b11 || (mode == 2'b01 && !tc)
                        || (os && m_st == 1));
      if (take) begin
        if (up_down) nv = (m_count >= max_value) ? 8'd0 : m_count + 8'd1;
        else         nv = (m_count == 0) ? max_value : m_count - 8'd1;
        rterm = up_down ? (nv >= max_value) : (nv == 0);
        if (tc && m_wrap != 4'hF) m_wrap = m_wrap + 4'd1;
        m_count = nv;
        m_pulse = rterm;
        if (os && m_st == 1 && rterm) m_st = 2;
      end else begin
        m_pulse = 0;
      end
    end
    if (!os) m_st = 0;
  endtask

  // Push the expected post-edge outputs, then clock and settle.
  task automatic tick();
    model_edge();
    sb.push_back({m_count, m_pulse, m_wrap, m_st == 1, m_st == 2});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 0; clear = 0; load = 0; start = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 1; clear = 0; load = 1; start = 1;
    load_value = 8'h33; max_value = 8'h09; up_down = 1; mode = 2'b10;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_mis++; $display("FAIL reset_sb got %h exp %h", obs, e); end
    n_cmp++;
    if (obs !== 15'd0) begin n_mis++; $display("FAIL reset_zero got %h exp 0000", obs); end
    reset_n = 1; idle_inputs(); mode = 2'b00;
  endtask

  task automatic test_priority();
    clear = 1; load = 1; enable = 1; load_value = 8'h77;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_mis++; $display("FAIL prio_clear_sb got %h exp %h", obs, e); end
    n_cmp++;
    if (count !== 8'h00) begin n_mis++; $display("FAIL prio_clear got %h exp 00", count); end
    clear = 0; load = 1; enable = 1; load_value = 8'h5A; max_value = 8'hFF;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_mis++; $display("FAIL prio_load_sb got %h exp %h", obs, e); end
    n_cmp++;
    if (count !== 8'h5A || tc_pulse !== 1'b0) begin
      n_mis++; $display("FAIL prio_load got %h/%b exp 5a/0", count, tc_pulse);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_up();
    logic exp_tc;
    mode = 2'b00; up_down = 1; max_value = 8'd9; clear = 1;
    tick(); void'(sb.pop_front());
    clear = 0; enable = 1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL wrap_up_sb i=%0d got %h exp %h", i, obs, e); end
      if (i <= 12) begin
        n_cmp++;
        if (count !== 8'(i % 10) || tc_pulse !== ((i % 10) == 9)) begin
          n_mis++; $display("FAIL wrap_up_seq i=%0d got %h/%b exp %h", i, count, tc_pulse, i % 10);
        end
        exp_tc = ((i % 10) == 9);
        n_cmp++;
        if (carry_out !== exp_tc || terminal_count !== exp_tc) begin
          n_mis++; $display("FAIL wrap_up_carry i=%0d got %b/%b exp %b", i, carry_out, terminal_count, exp_tc);
        end
      end
    end
    n_cmp++;
    if (wrap_count !== 4'hF) begin n_mis++; $display("FAIL wrap_sat got %h exp f", wrap_count); end
    // Reset in the middle of counting.
    reset_n = 0;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e || obs !== 15'd0) begin n_mis++; $display("FAIL reset_mid got %h exp 0000", obs); end
    reset_n = 1; idle_inputs();
  endtask

  task automatic test_wrap_down();
    logic [7:0] seq [4] = '{8'd0, 8'd3, 8'd2, 8'd1};
    mode = 2'b00; up_down = 0; max_value = 8'd3; clear = 1;
    tick(); void'(sb.pop_front());
    clear = 0; load = 1; load_value = 8'd1;
    tick(); void'(sb.pop_front());
    load = 0; enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e || count !== seq[i]) begin
        n_mis++; $display("FAIL wrap_down i=%0d got %h exp %h cnt %h", i, obs, e, seq[i]);
      end
    end
    n_cmp++;
    if (wrap_count !== 4'd1) begin n_mis++; $display("FAIL wrap_down_wc got %h exp 1", wrap_count); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    int pulses = 0;
    mode = 2'b01; up_down = 1; max_value = 8'hFF; clear = 1;
    tick(); void'(sb.pop_front());
    clear = 0; load = 1; load_value = 8'hFD;
    tick(); void'(sb.pop_front());
    load = 0; enable = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL sat_sb i=%0d got %h exp %h", i, obs, e); end
      n_cmp++;
      if (count !== ((i == 0) ? 8'hFE : 8'hFF) || carry_out !== 1'b0) begin
        n_mis++; $display("FAIL sat_seq i=%0d got %h/%b", i, count, carry_out);
      end
      if (tc_pulse === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || wrap_count !== 4'd0) begin
      n_mis++; $display("FAIL sat_pulses got %0d/%h exp 1/0", pulses, wrap_count);
    end
    idle_inputs();
  endtask

  task automatic test_oneshot();
    mode = 2'b10; up_down = 0; max_value = 8'd9; load_value = 8'd4; clear = 1;
    tick(); void'(sb.pop_front());
    clear = 0; start = 1;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e || count !== 8'd4 || running !== 1'b1) begin
      n_mis++; $display("FAIL os_start got %h exp %h", obs, e);
    end
    start = 0; enable = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL os_run_sb i=%0d got %h exp %h", i, obs, e); end
      n_cmp++;
      if (count !== ((i < 4) ? 8'(4 - i) : 8'd0) || running !== (i < 4) || done !== (i >= 4)
          || tc_pulse !== (i == 4)) begin
        n_mis++; $display("FAIL os_run i=%0d got %h", i, obs);
      end
    end
    start = 1;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e || count !== 8'd4 || running !== 1'b1) begin
      n_mis++; $display("FAIL os_rearm got %h exp %h", obs, e);
    end
    start = 0; mode = 2'b00;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e || running !== 1'b0 || done !== 1'b0) begin
      n_mis++; $display("FAIL os_mode_exit got %h exp %h", obs, e);
    end
    idle_inputs();
  endtask

  task automatic test_edges();
    mode = 2'b10; up_down = 0; load_value = 8'd0; clear = 1;
    tick(); void'(sb.pop_front());
    clear = 0; start = 1; enable = 1;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e || done !== 1'b1 || tc_pulse !== 1'b0 || count !== 8'd0) begin
      n_mis++; $display("FAIL os_zero got %h exp %h", obs, e);
    end
    idle_inputs();
    mode = 2'b00; up_down = 1; max_value = 8'd9; clear = 1;
    tick(); void'(sb.pop_front());
    clear = 0; load = 1; load_value = 8'd7;
    tick(); void'(sb.pop_front());
    load = 0; max_value = 8'd5; enable = 1;
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e || count !== 8'd0 || wrap_count !== 4'd1) begin
      n_mis++; $display("FAIL max_lower got %h exp %h", obs, e);
    end
    max_value = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e || count !== 8'd0 || tc_pulse !== 1'b1) begin
        n_mis++; $display("FAIL max_zero i=%0d got %h exp %h", i, obs, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      reset_n    = ($urandom_range(0, 99) != 0);
      clear      = ($urandom_range(0, 29) == 0);
      load       = ($urandom_range(0, 14) == 0);
      start      = ($urandom_range(0, 9) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up_down    = ($urandom_range(0, 7) != 0) ? up_down : ~up_down;
      mode       = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : mode;
      max_value  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 12)) : max_value;
      load_value = 8'($urandom_range(0, 14));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL random i=%0d got %h exp %h", i, obs, e); end
    end
    reset_n = 1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_oneshot();
    test_edges();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_mod_counter.md
Name: prog_mod_counter

Overview:
- Parametrised successor to the team's free-running N-bit counter.
- Adds:
  - programmable terminal value (modulus)
  - up/down direction
  - synchronous load and clear
  - three modes: wrap, saturate and one-shot (one-shot is FSM-controlled)
  - registered terminal pulse
  - combinational carry for cascading
  - wrap-event counter
- Used for LED/timer dividers and event timing on DE10-Lite designs.

Parameters:
- WIDTH, 16, counter width in bits (≥2).
- WRAP_W, 8, width of the wrap-event counter (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  step qualifier; a step occurs only on a cycle with enable=1.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value for load/start.
- max_value  in  WIDTH  terminal value when counting up; sampled every cycle.
- up_down  in  1  1=up, 0=down.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap).
- start  in  1  one-shot arm; ignored in other modes.
- count  out  WIDTH  current count (registered).
- terminal_count  out  1  combinational; up: count>=max_value; down: count==0.
- carry_out  out  1  combinational; enable & terminal_count & mode==wrap; cascade enable for next stage.
- tc_pulse  out  1  registered one-cycle pulse.
- wrap_count  out  WRAP_W  number of wraps, saturating at all-ones.
- running  out  1  one-shot FSM in RUN.
- done  out  1  one-shot FSM in DONE.

Behaviour:
- **Reset** (reset_n=0 at edge):
  - count=0, tc_pulse=0, wrap_count=0, FSM=IDLE (running=0, done=0).
  - Reset overrides every other input.
- **Priority:** reset_n > clear > load > start > step.
  - clear: count=0, wrap_count=0, FSM→IDLE, tc_pulse=0.
  - load: count=load_value; FSM state unchanged; tc_pulse=0.
- **Step arithmetic** (modulo 2^WIDTH):
  - Up: if count>=max_value then 0, else count+1.
  - Down: if count==0 then max_value, else count-1.
  - A step taken from the terminal state is a wrap.
- **Wrap mode:**
  - Steps every enabled cycle.
  - Each wrap increments wrap_count (holds at 2^WRAP_W-1).
- **Saturate mode:**
  - An enabled step is suppressed when terminal_count=1; count holds.
  - No wraps occur; wrap_count is unchanged.
- **One-shot mode, FSM IDLE/RUN/DONE:**
  - IDLE: no stepping; start → count=load_value, then:
    - next state RUN, or
    - DONE if load_value is already terminal for the current direction (no tc_pulse).
  - RUN: enabled steps; a step whose result is terminal → DONE.
  - DONE: holds count; start re-arms exactly as from IDLE.
  - clear → IDLE from any state.
  - Whenever mode≠one-shot, the FSM is forced to IDLE next cycle and start is ignored.
- **tc_pulse:**
  - High the cycle after any taken step whose result equals the terminal value for the direction.
  - Otherwise 0; never asserted by load, start or clear.
  - Wrap mode with max_value=0 and up: count stays 0 and tc_pulse is high after every enabled step.
- **Direction change:** takes effect on the next step; no extra latency.
- **max_value change below count while counting up:** the next step wraps to 0 and counts as a wrap.
- **Latency:**
  - count/tc_pulse: 1 cycle from the qualifying edge.
  - terminal_count/carry_out: combinational from count, max_value, up_down, enable, mode.

Decomposition:
- Package counter_pkg holds:
  - mode constants: MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10.
  - FSM state encodings: ST_IDLE, ST_RUN, ST_DONE.
- Optional sub-module oneshot_ctrl: the 3-state FSM, with outputs step_allow, running, done and load_start.
- Datapath stays in prog_mod_counter.

Test Plan:
All tests use WIDTH=8, WRAP_W=4.
- Reset and priority:
  - Drive clear, load and enable together → count=0.
  - Drive load=1 (load_value=0x5A) with enable=1 → count=0x5A, no step.
  - Hold reset_n=0 mid-count → all outputs 0 next edge.
- Wrap up:
  - Setup: max_value=9, enable held.
  - count runs 0..9,0; tc_pulse high the cycle count first shows 9.
  - carry_out high while count=9.
  - After 20 wraps, wrap_count=15 (saturated).
- Wrap down:
  - Setup: up_down=0, max_value=3, count=1.
  - Sequence 1,0,3,2; wrap_count +1 on the 0→3 step.
- Saturate:
  - Setup: max_value=0xFF, up, load 0xFD.
  - Sequence 0xFD,0xFE,0xFF then holds.
  - Exactly one tc_pulse; carry_out=0.
- One-shot:
  - Setup: down, load_value=4, start.
  - running=1 for 4 enabled steps.
  - count reaches 0 → done=1, tc_pulse once, count holds with enable=1.
  - start again → count=4, RUN.
  - Switching mode to wrap → IDLE next cycle.
- Edge cases:
  - One-shot start with load_value=0 going down → DONE immediately, no tc_pulse.
  - Up count=7 with max_value lowered to 5 → next step count=0, wrap_count+1.
